// File: rtl/cordic_vectoring.sv
// Vectoring-mode CORDIC: binary16 (x, y) in, atan2(y, x) in radians out as binary32.
// One request at a time: unpack/fold, ITERS micro-rotations, fixed-to-float pack.
module cordic_vectoring #(
  parameter int WIDTH = 16,
  parameter int ITERS = 14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [15:0] x_ieee754,
  input  logic [15:0] y_ieee754,
  output logic [31:0] angle_ieee754,
  output logic        ready,
  output logic        valid,
  output logic [1:0]  state_dbg
);
  // Handshake: a request is taken on a rising edge where valid_in and ready are
  // both high; valid is a one-cycle strobe with no backpressure, and valid_in is
  // ignored (not queued) whenever ready is low.

  localparam int DW   = WIDTH + 2;
  localparam int FRAC = WIDTH - 3;
  localparam int CW   = $clog2(ITERS);
  localparam logic [63:0] PI_Q29 = 64'd1686629713;
  localparam logic signed [WIDTH-1:0] PI_Q =
    WIDTH'((PI_Q29 + (64'd1 << (28 - FRAC))) >> (29 - FRAC));

  typedef enum logic [1:0] {IDLE = 2'd0, UNPACK = 2'd1, ITER = 2'd2, PACK = 2'd3} state_t;

  // atan(2^-i) held as Q0.30, rounded to the accumulator's fraction width.
  function automatic logic signed [WIDTH-1:0] atan_q(input int i);
    logic [63:0] c;
    case (i)
      0:       c = 64'd843314857;
      1:       c = 64'd497837830;
      2:       c = 64'd263043837;
      3:       c = 64'd133525159;
      4:       c = 64'd67021688;
      5:       c = 64'd33543515;
      6:       c = 64'd16775851;
      7:       c = 64'd8388437;
      8:       c = 64'd4194283;
      9:       c = 64'd2097149;
      default: c = (i > 30) ? 64'd0 : (64'd1 << (30 - i));
    endcase
    return WIDTH'((c + (64'd1 << (29 - FRAC))) >> (30 - FRAC));
  endfunction

  state_t state_q, state_n;
  logic [15:0]             xh_q, yh_q;
  logic signed [DW-1:0]    x_q, y_q;
  logic signed [WIDTH-1:0] z_q, off_q;
  logic                    nan_q, zero_q;
  logic [CW-1:0]           iter_q;
  logic [31:0]             angle_q;
  logic                    valid_q;

  // Unpack and quadrant fold
  logic [4:0]              ex, ey, ex_eff, ey_eff, diff;
  logic [13:0]             px, py, ax, ay, big;
  logic [3:0]              nsh;
  logic [DW-1:0]           ux, uy;
  logic signed [DW-1:0]    x0, y0;
  logic signed [WIDTH-1:0] off0;
  logic                    nan0, zero0;

  always_comb begin
    ex     = xh_q[14:10];
    ey     = yh_q[14:10];
    ex_eff = (ex == 5'd0) ? 5'd1 : ex;
    ey_eff = (ey == 5'd0) ? 5'd1 : ey;
    px     = {(ex != 5'd0), xh_q[9:0], 3'b000};
    py     = {(ey != 5'd0), yh_q[9:0], 3'b000};
    if (ex_eff >= ey_eff) begin
      diff = ex_eff - ey_eff;
      ax   = px;
      ay   = (diff >= 5'd14) ? 14'd0 : (py >> diff);
    end else begin
      diff = ey_eff - ex_eff;
      ax   = (diff >= 5'd14) ? 14'd0 : (px >> diff);
      ay   = py;
    end
    // Two subnormals share exponent 1: normalise both together so the larger
    // lands at bit 13 and the rotations keep full precision.
    big = ax | ay;
    nsh = '0;
    for (int b = 0; b < 14; b++) begin
      if (big[b]) nsh = 4'(13 - b);
    end
    ux = {{(DW-14){1'b0}}, ax} << nsh;
    uy = {{(DW-14){1'b0}}, ay} << nsh;
    x0 = ux;
    if (xh_q[15]) begin
      y0   = yh_q[15] ? uy : -uy;
      off0 = (yh_q[15] && (yh_q[14:0] != 15'd0)) ? -PI_Q : PI_Q;
    end else begin
      y0   = yh_q[15] ? -uy : uy;
      off0 = '0;
    end
    nan0  = (ex == 5'h1F) || (ey == 5'h1F);
    zero0 = (xh_q[14:0] == 15'd0) && (yh_q[14:0] == 15'd0);
  end

  // One micro-rotation; d = +1 when y < 0
  logic signed [DW-1:0]    xs, ys, x_n, y_n;
  logic signed [WIDTH-1:0] at, z_n;

  always_comb begin
    xs = x_q >>> iter_q;
    ys = y_q >>> iter_q;
    at = atan_q(int'(iter_q));
    if (y_q[DW-1]) begin
      x_n = x_q - ys;
      y_n = y_q + xs;
      z_n = z_q - at;
    end else begin
      x_n = x_q + ys;
      y_n = y_q - xs;
      z_n = z_q + at;
    end
  end

  // Fixed-to-float pack with truncated mantissa
  logic signed [WIDTH-1:0] a;
  logic [WIDTH-1:0]        mag;
  int                      p;
  logic [31:0]             pack_val;

  always_comb begin
    a   = z_q + off_q;
    mag = a[WIDTH-1] ? -a : a;
    p   = 0;
    for (int b = 0; b < WIDTH; b++) begin
      if (mag[b]) p = b;
    end
    if (nan_q)
      pack_val = 32'h7FC0_0000;
    else if (zero_q || (a == '0))
      pack_val = 32'h0000_0000;
    else
      pack_val = {a[WIDTH-1], 8'(127 + p - FRAC),
                  23'({{(32-WIDTH){1'b0}}, mag} << (23 - p))};
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (valid_in) state_n = UNPACK;
      UNPACK:  state_n = ITER;
      ITER:    if (iter_q == CW'(ITERS - 1)) state_n = PACK;
      PACK:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      xh_q    <= '0;
      yh_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      off_q   <= '0;
      nan_q   <= 1'b0;
      zero_q  <= 1'b0;
      iter_q  <= '0;
      angle_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_n;
      valid_q <= (state_q == PACK);
      case (state_q)
        IDLE: begin
          if (valid_in) begin
            xh_q <= x_ieee754;
            yh_q <= y_ieee754;
          end
        end
        UNPACK: begin
          x_q    <= x0;
          y_q    <= y0;
          z_q    <= '0;
          off_q  <= off0;
          nan_q  <= nan0;
          zero_q <= zero0;
          iter_q <= '0;
        end
        ITER: begin
          x_q    <= x_n;
          y_q    <= y_n;
          z_q    <= z_n;
          iter_q <= iter_q + 1'b1;
        end
        PACK:    angle_q <= pack_val;
        default: ;
      endcase
    end
  end

  assign ready         = (state_q == IDLE);
  assign valid         = valid_q;
  assign angle_ieee754 = angle_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_cordic_vectoring.sv
// Bench for cordic_vectoring: directed, randomized, handshake and reset scenarios
// checked against a real-arithmetic atan2 reference.
module tb_cordic_vectoring;
  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [15:0] x_in, y_in;
  logic [31:0] angle;
  logic        ready, valid;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  localparam real TOL = 1.0 / 1024.0;

  // {tolerant_compare, expected binary32}
  logic [32:0] exp_q[$];

  cordic_vectoring dut (
    .clk(clk), .rst(rst), .valid_in(valid_in),
    .x_ieee754(x_in), .y_ieee754(y_in),
    .angle_ieee754(angle), .ready(ready), .valid(valid), .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // reference model helpers
  function automatic real pow2(input int e);
    real r = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
    else        for (int i = 0; i < -e; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real half_to_real(input logic [15:0] h);
    real m;
    int  e;
    e = int'(h[14:10]);
    m = real'(h[9:0]) / 1024.0;
    if (e == 0) e = 1;
    else        m = m + 1.0;
    m = m * pow2(e - 15);
    if (h[15] && (h[14:0] != 15'd0)) m = -m;
    return m;
  endfunction

  function automatic real f32_to_real(input logic [31:0] f);
    real m;
    if (f[30:23] == 8'd0) return 0.0;
    m = (1.0 + real'(f[22:0]) / 8388608.0) * pow2(int'(f[30:23]) - 127);
    return f[31] ? -m : m;
  endfunction

  function automatic logic [31:0] real_to_f32(input real r);
    real  m;
    int   e;
    logic s;
    if (r == 0.0) return 32'h0;
    s = (r < 0.0);
    m = s ? -r : r;
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    return {s, 8'(e + 127), 23'($rtoi((m - 1.0) * 8388608.0))};
  endfunction

  function automatic logic [32:0] model(input logic [15:0] x, input logic [15:0] y);
    if ((x[14:10] == 5'h1F) || (y[14:10] == 5'h1F)) return {1'b0, 32'h7FC0_0000};
    if ((x[14:0] == 15'd0) && (y[14:0] == 15'd0))   return {1'b0, 32'h0};
    return {1'b1, real_to_f32($atan2(half_to_real(y), half_to_real(x)))};
  endfunction

  function automatic logic [15:0] rand_half();
    logic [15:0] h;
    int          sel;
    sel      = $urandom_range(0, 15);
    h[15]    = 1'($urandom_range(0, 1));
    h[14:10] = 5'($urandom_range(0, 30));
    h[9:0]   = 10'($urandom);
    if (sel == 0)      h[14:10] = 5'h1F;
    else if (sel == 1) h[14:0]  = 15'd0;
    return h;
  endfunction

  // driver: issue one request, wait for its result (bounded)
  task automatic run_one(input logic [15:0] x, input logic [15:0] y,
                         output logic [31:0] got, output int lat);
    int k = 0;
    @(negedge clk);
    while (!ready && k < 40) begin @(negedge clk); k++; end
    x_in = x; y_in = y; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    lat = -1;
    got = '0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (valid) begin lat = c; got = angle; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; valid_in = 1'b0; x_in = '0; y_in = '0;
    #1;
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_checks++; if (angle !== 32'h0) begin n_fail++; $display("FAIL reset_angle: got %h want 00000000", angle); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_directed();
    logic [15:0] dx[8] = '{16'h3C00, 16'h0000, 16'hBC00, 16'hBC00, 16'h7E00, 16'h8000, 16'h7BFF, 16'h0001};
    logic [15:0] dy[8] = '{16'h3C00, 16'h3C00, 16'h0000, 16'hBC00, 16'h3C00, 16'h0000, 16'h0001, 16'h0001};
    logic [32:0] de[8] = '{{1'b1, 32'h3F490FDB}, {1'b1, 32'h3FC90FDB}, {1'b1, 32'h40490FDB},
                           {1'b1, 32'hC016CBE4}, {1'b0, 32'h7FC00000}, {1'b0, 32'h00000000},
                           {1'b1, 32'h00000000}, {1'b1, 32'h3F490FDB}};
    logic [31:0] got;
    logic [32:0] e;
    int          lat;
    real         err;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(de[i]);
      run_one(dx[i], dy[i], got, lat);
      e = exp_q.pop_front();
      n_checks++;
      if (lat != 16) begin n_fail++; $display("FAIL directed_latency[%0d]: got %0d want 16", i, lat); end
      n_checks++;
      if (e[32]) begin
        err = f32_to_real(got) - f32_to_real(e[31:0]);
        if (err < 0.0) err = -err;
        if (lat < 0 || err > TOL) begin
          n_fail++; $display("FAIL directed_value[%0d]: got %h want %h (err %f)", i, got, e[31:0], err);
        end
      end else if (lat < 0 || got !== e[31:0]) begin
        n_fail++; $display("FAIL directed_value[%0d]: got %h want %h", i, got, e[31:0]);
      end
      @(posedge clk); #1;
      n_checks++;
      if (valid !== 1'b0) begin n_fail++; $display("FAIL directed_pulse[%0d]: valid %b want 0", i, valid); end
    end
  endtask

  task automatic test_random();
    logic [15:0] x, y;
    logic [31:0] got;
    logic [32:0] e;
    int          lat;
    real         err;
    for (int i = 0; i < 40; i++) begin
      x = rand_half();
      y = rand_half();
      exp_q.push_back(model(x, y));
      run_one(x, y, got, lat);
      e = exp_q.pop_front();
      n_checks++;
      if (lat != 16) begin n_fail++; $display("FAIL random_latency x=%h y=%h: got %0d want 16", x, y, lat); end
      n_checks++;
      if (e[32]) begin
        err = f32_to_real(got) - f32_to_real(e[31:0]);
        if (err < 0.0) err = -err;
        if (lat < 0 || err > TOL) begin
          n_fail++; $display("FAIL random_value x=%h y=%h: got %h want %h (err %f)", x, y, got, e[31:0], err);
        end
      end else if (lat < 0 || got !== e[31:0]) begin
        n_fail++; $display("FAIL random_value x=%h y=%h: got %h want %h", x, y, got, e[31:0]);
      end
    end
  endtask

  task automatic test_ignore();
    int          pulses = 0, first_c = -1, k = 0;
    logic [31:0] got = '0;
    logic [32:0] e;
    real         err;
    @(negedge clk);
    while (!ready && k < 40) begin @(negedge clk); k++; end
    exp_q.push_back({1'b1, 32'h3F490FDB});
    x_in = 16'h3C00; y_in = 16'h3C00; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    x_in = 16'hBC00; y_in = 16'hBC00; valid_in = 1'b1;
    n_checks++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL ignore_ready: got %b want 0", ready); end
    @(posedge clk); #1;
    valid_in = 1'b0;
    for (int c = 4; c <= 40; c++) begin
      @(posedge clk); #1;
      if (valid) begin
        pulses++;
        if (first_c < 0) begin first_c = c; got = angle; end
      end
    end
    e = exp_q.pop_front();
    n_checks++;
    if (pulses != 1) begin n_fail++; $display("FAIL ignore_pulses: got %0d want 1", pulses); end
    n_checks++;
    if (first_c != 16) begin n_fail++; $display("FAIL ignore_latency: got %0d want 16", first_c); end
    err = f32_to_real(got) - f32_to_real(e[31:0]);
    if (err < 0.0) err = -err;
    n_checks++;
    if (err > TOL) begin n_fail++; $display("FAIL ignore_value: got %h want %h", got, e[31:0]); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] bx[3], by[3];
    logic [31:0] got;
    logic [32:0] e;
    int          t_prev, t, lat, extra = 0, k = 0;
    real         err;
    for (int i = 0; i < 3; i++) begin
      bx[i] = {1'($urandom_range(0, 1)), 5'($urandom_range(1, 30)), 10'($urandom)};
      by[i] = {1'($urandom_range(0, 1)), 5'($urandom_range(1, 30)), 10'($urandom)};
      exp_q.push_back(model(bx[i], by[i]));
    end
    @(negedge clk);
    while (!ready && k < 40) begin @(negedge clk); k++; end
    x_in = bx[0]; y_in = by[0]; valid_in = 1'b1;
    @(posedge clk); #1;
    t_prev = cyc;
    for (int r = 0; r < 3; r++) begin
      lat = -1;
      got = '0;
      for (int c = 1; c <= 40; c++) begin
        @(posedge clk); #1;
        if (valid) begin lat = c; got = angle; break; end
      end
      t = cyc;
      if (r < 2) begin x_in = bx[r+1]; y_in = by[r+1]; end
      else valid_in = 1'b0;
      n_checks++;
      if (lat < 0 || (t - t_prev) != ((r == 0) ? 16 : 17)) begin
        n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d want %0d", r, (lat < 0) ? -1 : t - t_prev, (r == 0) ? 16 : 17);
      end
      t_prev = t;
      e = exp_q.pop_front();
      err = f32_to_real(got) - f32_to_real(e[31:0]);
      if (err < 0.0) err = -err;
      n_checks++;
      if (lat < 0 || err > TOL) begin
        n_fail++; $display("FAIL b2b_value[%0d]: got %h want %h (err %f)", r, got, e[31:0], err);
      end
    end
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (valid) extra++;
    end
    n_checks++;
    if (extra != 0) begin n_fail++; $display("FAIL b2b_extra_valid: got %0d want 0", extra); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] got;
    int          lat, stale = 0, k = 0;
    real         err;
    @(negedge clk);
    while (!ready && k < 40) begin @(negedge clk); k++; end
    x_in = 16'hBC00; y_in = 16'h3C00; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", valid); end
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b want 1", ready); end
    n_checks++; if (angle !== 32'h0) begin n_fail++; $display("FAIL midrst_angle: got %h want 00000000", angle); end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (valid) stale++;
    end
    n_checks++;
    if (stale != 0) begin n_fail++; $display("FAIL midrst_stale_valid: got %0d want 0", stale); end
    run_one(16'h3C00, 16'h3C00, got, lat);
    n_checks++;
    if (lat != 16) begin n_fail++; $display("FAIL midrst_recover_latency: got %0d want 16", lat); end
    err = f32_to_real(got) - f32_to_real(32'h3F490FDB);
    if (err < 0.0) err = -err;
    n_checks++;
    if (lat < 0 || err > TOL) begin n_fail++; $display("FAIL midrst_recover_value: got %h want 3f490fdb", got); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cordic_vectoring.md
# cordic_vectoring

Inverse of the angle-to-sine/cosine path: accepts a Cartesian pair (x, y) in IEEE 754 binary16 and returns atan2(y, x) in radians as IEEE 754 binary32. It is an iterative CORDIC in vectoring mode with a front-end unpacker and quadrant fold, plus a back-end fixed-to-float packer. It sits next to the rotation path and consumes the same half-precision cos/sin format that path produces, so a round trip angle → (cos, sin) → angle is checkable in one bench.

## Interface
- WIDTH, 16: angle accumulator width, format Q3.(WIDTH-3), two's complement; x/y datapath is WIDTH+2 bits signed.
- ITERS, 14: CORDIC micro-rotations; atan table holds ITERS entries of atan(2^-i) rounded to Q3.(WIDTH-3).
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- valid_in  in  1  request strobe; sampled only while ready=1.
- x_ieee754  in  16  x operand, binary16.
- y_ieee754  in  16  y operand, binary16.
- angle_ieee754  out  32  atan2(y, x), binary32, range [-pi, pi].
- ready  out  1  high in IDLE only.
- valid  out  1  one-cycle pulse marking a new angle_ieee754.

## Operation
- States: IDLE → UNPACK → ITER → PACK → IDLE.
- IDLE: ready=1. valid_in=1 registers x, y; go UNPACK. valid_in while not IDLE is ignored (no queueing).
- UNPACK (1 cycle): significand = {hidden, frac10}, hidden=0 for exponent 0 (subnormal, effective exponent 1). Larger exponent sets scale; smaller-exponent operand right-shifted by the exponent difference, zero if difference ≥ 14. Significand placed with hidden bit at datapath bit 13; apply sign.
- Quadrant fold in UNPACK: if x<0, negate x and y; offset = +pi if original y ≥ 0 (incl. ±0), else -pi. Otherwise offset = 0. z initialised to 0.
- Special flags set in UNPACK: any operand exponent 0x1F (Inf/NaN) → NAN; both operands zero (either sign) → ZERO. Flagged requests still traverse ITER so latency is constant.
- ITER (ITERS cycles, i = 0..ITERS-1): d = +1 if y < 0 else -1; x' = x - d·(y>>>i); y' = y + d·(x>>>i); z' = z - d·atan_tab[i]. Arithmetic shifts; no saturation needed (growth ≤ 1.647·√2 fits WIDTH+2).
- PACK (1 cycle): a = z + offset in Q3.(WIDTH-3). Convert: sign = a[MSB]; magnitude = |a|; leading-one position p; exponent = 127 + p - (WIDTH-3); mantissa = bits below the leading one, left-justified into 23 bits, truncated. a=0 → 0x00000000. NAN → 0x7FC00000. ZERO → 0x00000000. Register angle_ieee754, assert valid, return IDLE.
- Accuracy: |result - atan2(y,x)| ≤ 2^-10 rad for all finite non-(0,0) inputs.

## Timing
- Reset values: state IDLE, ready=1, valid=0, angle_ieee754=0x00000000, internal x/y/z/offset/flags 0.
- Latency: valid rises ITERS+2 rising edges after the accepting edge (16 at defaults), identical for special cases.
- ready falls the edge after acceptance, rises the edge valid rises; throughput one result per ITERS+3 cycles.
- valid high exactly one cycle; angle_ieee754 held until the next PACK.
- valid_in and ready high in the same cycle as valid: the new request is accepted (back-to-back).
- rst asserted mid-operation: immediate abort to reset values; no valid for the aborted request.

## Test plan
- x=0x3C00, y=0x3C00 → 0x3F490FDB (pi/4) ±2^-10 rad; x=0x0000, y=0x3C00 → 0x3FC90FDB (pi/2) ±tol; valid exactly 16 cycles after accept.
- x=0xBC00, y=0x0000 → 0x40490FDB (pi); x=0xBC00, y=0xBC00 → 0xC016CBE4 (-3pi/4); both ±2^-10 rad.
- x=0x7E00 (NaN), y=0x3C00 → 0x7FC00000; x=0x8000, y=0x0000 → 0x00000000; both after 16 cycles.
- x=0x7BFF, y=0x0001 (exponent gap ≥ 14) → |angle| ≤ 2^-10; x=0x0001, y=0x0001 (subnormals) → pi/4 ±tol.
- Second valid_in pulse 3 cycles after acceptance → ignored, single valid pulse; valid_in held high → back-to-back results every 17 cycles.
- rst low during ITER → valid=0, ready=1, angle_ieee754=0 immediately; no stale valid after release.
